// File: rtl/piton_vortex_define.sv
// -----------------------------------------------------------------------------
// piton_vortex_define
// Shared definitions for the Piton <-> Vortex DCR write path.
//   dcr_arb_state_e        : write-arbiter FSM state encoding
//   VX_DCR_*_WIDTH_DEF     : default DCR address/data widths
//   idx_width()            : index width for an N-entry vector (minimum 1)
// -----------------------------------------------------------------------------
package piton_vortex_define;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } dcr_arb_state_e;

    localparam int unsigned VX_DCR_ADDR_WIDTH_DEF = 8;
    localparam int unsigned VX_DCR_DATA_WIDTH_DEF = 32;

    // Width needed to index n entries; a single entry still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_rr_pick.sv
// -----------------------------------------------------------------------------
// vx_rr_pick
// Combinational round-robin priority picker: first set bit of i_valid at or
// above i_ptr, wrapping around.
//   i_valid [NUM_REQ]  request vector
//   i_ptr   [IW]       highest-priority index
//   o_grant [NUM_REQ]  one-hot winner (zero when nothing is valid)
//   o_idx   [IW]       winner index
//   o_any              at least one request valid
// -----------------------------------------------------------------------------
module vx_rr_pick
    import piton_vortex_define::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]               i_valid,
    input  logic [idx_width(NUM_REQ)-1:0]    i_ptr,
    output logic [NUM_REQ-1:0]               o_grant,
    output logic [idx_width(NUM_REQ)-1:0]    o_idx,
    output logic                             o_any
);

    localparam int unsigned IW = idx_width(NUM_REQ);

    // Walk NUM_REQ positions starting at the pointer; first hit wins.
    always_comb begin
        int unsigned w_j;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_j     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_j = (32'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_valid[w_j]) begin
                o_any        = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/vx_dcr_write_arbiter.sv
// -----------------------------------------------------------------------------
// vx_dcr_write_arbiter
// Round-robin arbiter sharing the Vortex DCR write path between NUM_REQ
// requesters. A grant latches address/data, the write goes out as a one-cycle
// strobe once the buffer is ready, then address/data are held for HOLD_CYCLES
// so the buffer's two-flop valid synchronizer samples stable data.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/addr/data      per-requester write request (slice i = requester i)
//   req_ready                one-hot accept pulse (combinational, IDLE only)
//   req_lock                 burst lock (used only with VX_DCR_ARB_LOCK_EN)
//   dcr_buffer_wr_valid      single-cycle write strobe
//   dcr_buffer_wr_addr/data  registered address/data
//   vx_buffer_rdy            DCR buffer not full
//   grant_id                 index of the last granted requester
//   wr_count                 writes issued downstream (wraps)
//
// Optional feature macro: VX_DCR_ARB_LOCK_EN -- a grant taken with req_lock
// high keeps the next grant on the same requester while it stays valid.
// -----------------------------------------------------------------------------
module vx_dcr_write_arbiter
    import piton_vortex_define::*;
#(
    parameter int unsigned NUM_REQ           = 2,
    parameter int unsigned VX_DCR_ADDR_WIDTH = VX_DCR_ADDR_WIDTH_DEF,
    parameter int unsigned VX_DCR_DATA_WIDTH = VX_DCR_DATA_WIDTH_DEF,
    parameter int unsigned HOLD_CYCLES       = 3,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*VX_DCR_ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*VX_DCR_DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]                     req_ready,
    input  logic [NUM_REQ-1:0]                     req_lock,
    output logic                                   dcr_buffer_wr_valid,
    output logic [VX_DCR_ADDR_WIDTH-1:0]           dcr_buffer_wr_addr,
    output logic [VX_DCR_DATA_WIDTH-1:0]           dcr_buffer_wr_data,
    input  logic                                   vx_buffer_rdy,
    output logic [idx_width(NUM_REQ)-1:0]          grant_id,
    output logic [CNT_WIDTH-1:0]                   wr_count
);

    localparam int unsigned IW = idx_width(NUM_REQ);
    localparam int unsigned HW = idx_width(HOLD_CYCLES);

    dcr_arb_state_e               r_state;
    dcr_arb_state_e               w_next_state;
    logic [IW-1:0]                r_rr_ptr;
    logic [IW-1:0]                r_grant_id;
    logic [VX_DCR_ADDR_WIDTH-1:0] r_addr;
    logic [VX_DCR_DATA_WIDTH-1:0] r_data;
    logic [CNT_WIDTH-1:0]         r_wr_count;
    logic [HW-1:0]                r_hold_cnt;

    logic [NUM_REQ-1:0]           w_pick_oh;
    logic [IW-1:0]                w_pick_idx;
    logic                         w_any;
    logic [NUM_REQ-1:0]           w_sel_oh;
    logic [IW-1:0]                w_sel_idx;
    logic [IW-1:0]                w_inc_ptr;
    logic [IW-1:0]                w_next_ptr;
    logic                         w_grant;
    logic                         w_xfer;

    vx_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_any   (w_any)
    );

    // Pointer moves to the slot just after the winner.
    always_comb begin
        w_inc_ptr = (32'(w_sel_idx) == NUM_REQ - 1) ? '0 : w_sel_idx + IW'(1);
    end

`ifdef VX_DCR_ARB_LOCK_EN
    logic r_lock;
    logic w_lock_hit;

    // A locked owner that is still requesting pre-empts round-robin.
    always_comb begin
        w_lock_hit = r_lock && req_valid[r_grant_id];
        w_sel_oh   = w_lock_hit ? (NUM_REQ'(1) << r_grant_id) : w_pick_oh;
        w_sel_idx  = w_lock_hit ? r_grant_id : w_pick_idx;
        w_next_ptr = req_lock[w_sel_idx] ? r_rr_ptr : w_inc_ptr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock <= 1'b0;
        end else if (w_grant) begin
            r_lock <= req_lock[w_sel_idx];
        end
    end
`else
    logic w_unused_lock;

    always_comb begin
        w_sel_oh   = w_pick_oh;
        w_sel_idx  = w_pick_idx;
        w_next_ptr = w_inc_ptr;
    end

    assign w_unused_lock = ^req_lock;
`endif

    assign w_grant = (r_state == ST_IDLE) && w_any;
    assign w_xfer  = (r_state == ST_SEND) && vx_buffer_rdy;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_any)              w_next_state = ST_SEND;
            ST_SEND: if (vx_buffer_rdy)      w_next_state = ST_HOLD;
            ST_HOLD: if (r_hold_cnt == '0)   w_next_state = ST_IDLE;
            default:                         w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs; reset forces them low even with requests pending.
    always_comb begin
        req_ready           = '0;
        dcr_buffer_wr_valid = 1'b0;
        if (!rst) begin
            if (r_state == ST_IDLE) req_ready = w_sel_oh;
            if (r_state == ST_SEND) dcr_buffer_wr_valid = vx_buffer_rdy;
        end
    end

    // Grant bookkeeping, output data registers, write counter and hold timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_wr_count <= '0;
            r_hold_cnt <= '0;
        end else begin
            if (w_grant) begin
                r_grant_id <= w_sel_idx;
                r_rr_ptr   <= w_next_ptr;
                r_addr     <= req_addr[32'(w_sel_idx) * VX_DCR_ADDR_WIDTH +: VX_DCR_ADDR_WIDTH];
                r_data     <= req_data[32'(w_sel_idx) * VX_DCR_DATA_WIDTH +: VX_DCR_DATA_WIDTH];
            end
            if (w_xfer) begin
                r_wr_count <= r_wr_count + CNT_WIDTH'(1);
                r_hold_cnt <= HW'(HOLD_CYCLES - 1);
            end else if ((r_state == ST_HOLD) && (r_hold_cnt != '0)) begin
                r_hold_cnt <= r_hold_cnt - HW'(1);
            end
        end
    end

    assign dcr_buffer_wr_addr = r_addr;
    assign dcr_buffer_wr_data = r_data;
    assign grant_id           = r_grant_id;
    assign wr_count           = r_wr_count;

    // A waiting requester must keep valid up until it is accepted.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_proto
        a_valid_held: assert property (@(posedge clk) disable iff (rst)
            (req_valid[i] && !req_ready[i]) |=> req_valid[i]);
    end

endmodule

// File: tb/tb_vx_dcr_write_arbiter.sv
module tb_vx_dcr_write_arbiter;

    localparam int unsigned NR   = 2;
    localparam int unsigned AW   = 8;
    localparam int unsigned DW   = 32;
    localparam int unsigned HOLD = 3;
    localparam int unsigned CW   = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   req_lock;
    logic            wr_valid;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            buf_rdy;
    logic [0:0]      grant_id;
    logic [CW-1:0]   wr_count;

    vx_dcr_write_arbiter #(
        .NUM_REQ           (NR),
        .VX_DCR_ADDR_WIDTH (AW),
        .VX_DCR_DATA_WIDTH (DW),
        .HOLD_CYCLES       (HOLD),
        .CNT_WIDTH         (CW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_valid           (req_valid),
        .req_addr            (req_addr),
        .req_data            (req_data),
        .req_ready           (req_ready),
        .req_lock            (req_lock),
        .dcr_buffer_wr_valid (wr_valid),
        .dcr_buffer_wr_addr  (wr_addr),
        .dcr_buffer_wr_data  (wr_data),
        .vx_buffer_rdy       (buf_rdy),
        .grant_id            (grant_id),
        .wr_count            (wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          lk;
    } wr_t;

    wr_t q0[$];
    wr_t q1[$];

    int n_checks = 0;
    int n_errors = 0;

    // Model state (what the outputs must be, tracked by cycle number).
    int          m_cyc = 0;
    int          m_free_at = 0;
    bit          m_pending = 0;
    int          m_ptr = 0;
    bit          m_lock = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic [0:0]    m_gid = '0;
    logic [CW-1:0] m_cnt = '0;

    // Observation logs used by the literal checks.
    int          rdy_cyc[$];
    int          rdy_idx[$];
    int          stb_cyc[$];
    logic [AW-1:0] stb_addr[$];
    logic [DW-1:0] stb_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_first(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < int'(NR); k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return 0;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Requester behaviour: present the queue head, pop once it was accepted.
    initial begin : drv
        logic [NR-1:0] seen;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_lock  = '0;
        forever begin
            @(negedge clk);
            seen = req_ready;
            @(posedge clk);
            #2;
            if (seen[0] && q0.size() != 0) void'(q0.pop_front());
            if (seen[1] && q1.size() != 0) void'(q1.pop_front());
            req_valid[0]      = (q0.size() != 0);
            req_addr[AW-1:0]  = (q0.size() != 0) ? q0[0].a  : '0;
            req_data[DW-1:0]  = (q0.size() != 0) ? q0[0].d  : '0;
            req_lock[0]       = (q0.size() != 0) ? q0[0].lk : 1'b0;
            req_valid[1]      = (q1.size() != 0);
            req_addr[2*AW-1:AW] = (q1.size() != 0) ? q1[0].a  : '0;
            req_data[2*DW-1:DW] = (q1.size() != 0) ? q1[0].d  : '0;
            req_lock[1]       = (q1.size() != 0) ? q1[0].lk : 1'b0;
        end
    end

    // Compare process: every cycle, derive expected outputs and check them.
    initial begin : cmp
        logic [NR-1:0] e_rdy;
        logic          e_val;
        int            g;
        int            n_ptr;
        bit            n_lock;
        bit            n_pending;
        int            n_free;
        logic [AW-1:0] n_addr;
        logic [DW-1:0] n_data;
        logic [0:0]    n_gid;
        logic [CW-1:0] n_cnt;
        forever begin
            @(negedge clk);
            e_rdy = '0;
            e_val = 1'b0;
            g = 0;
            if (rst) begin
                m_addr = '0; m_data = '0; m_gid = '0; m_cnt = '0;
                m_ptr = 0; m_lock = 0; m_pending = 0; m_free_at = 0;
            end
            n_addr = m_addr; n_data = m_data; n_gid = m_gid; n_cnt = m_cnt;
            n_ptr = m_ptr; n_lock = m_lock; n_pending = m_pending; n_free = m_free_at;
            if (!rst) begin
                if (m_pending) begin
                    if (buf_rdy) begin
                        e_val     = 1'b1;
                        n_cnt     = m_cnt + 1'b1;
                        n_pending = 0;
                        n_free    = m_cyc + int'(HOLD) + 1;
                    end
                end else if (m_cyc >= m_free_at && req_valid != '0) begin
`ifdef VX_DCR_ARB_LOCK_EN
                    if (m_lock && req_valid[m_gid]) g = int'(m_gid);
                    else g = rr_first(req_valid, m_ptr);
                    n_ptr  = req_lock[g] ? m_ptr : (g + 1) % NR;
                    n_lock = req_lock[g];
`else
                    g = rr_first(req_valid, m_ptr);
                    n_ptr = (g + 1) % NR;
`endif
                    e_rdy[g]  = 1'b1;
                    n_addr    = req_addr[g*AW +: AW];
                    n_data    = req_data[g*DW +: DW];
                    n_gid     = 1'(g);
                    n_pending = 1;
                end
            end
            check("req_ready", 32'(req_ready), 32'(e_rdy));
            check("wr_valid",  32'(wr_valid),  32'(e_val));
            check("wr_addr",   32'(wr_addr),   32'(m_addr));
            check("wr_data",   wr_data,        m_data);
            check("grant_id",  32'(grant_id),  32'(m_gid));
            check("wr_count",  32'(wr_count),  32'(m_cnt));
            if (req_ready != '0) begin
                rdy_cyc.push_back(m_cyc);
                rdy_idx.push_back(req_ready[1] ? 1 : 0);
            end
            if (wr_valid) begin
                stb_cyc.push_back(m_cyc);
                stb_addr.push_back(wr_addr);
                stb_data.push_back(wr_data);
            end
            if (!rst) begin
                m_addr = n_addr; m_data = n_data; m_gid = n_gid; m_cnt = n_cnt;
                m_ptr = n_ptr; m_lock = n_lock; m_pending = n_pending; m_free_at = n_free;
            end
            m_cyc++;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        repeat (2) next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || m_pending || m_cyc <= m_free_at) && n < budget) begin
            next_cycle();
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_errors++;
            $display("FAIL wait_quiet: still busy after %0d cycles", n);
        end
    endtask

    task automatic wait_grant(input int base);
        int n;
        n = 0;
        while (rdy_cyc.size() == base && n < 20) begin
            next_cycle();
            n++;
        end
        check("grant_seen", 32'(rdy_cyc.size() > base), 32'd1);
    endtask

    task automatic wait_strobe(input int base);
        int n;
        n = 0;
        while (stb_cyc.size() == base && n < 20) begin
            next_cycle();
            n++;
        end
        check("strobe_seen", 32'(stb_cyc.size() > base), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int rb;
        int sb;
        rst     = 1'b1;
        buf_rdy = 1'b1;
        repeat (3) next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single write from requester 0.
        rb = rdy_cyc.size(); sb = stb_cyc.size();
        q0.push_back('{a: 8'h01, d: 32'hDEADBEEF, lk: 1'b0});
        wait_quiet(40);
        check("t1_nstb",  32'(stb_cyc.size() - sb), 32'd1);
        check("t1_lat",   32'(stb_cyc[sb] - rdy_cyc[rb]), 32'd1);
        check("t1_addr",  32'(stb_addr[sb]), 32'h01);
        check("t1_data",  stb_data[sb], 32'hDEADBEEF);
        check("t1_hold",  32'(wr_addr), 32'h01);
        check("t1_count", 32'(wr_count), 32'd1);

        // Contention: four writes per requester, alternating grants.
        do_reset();
        rb = rdy_cyc.size(); sb = stb_cyc.size();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{a: 8'(8'h10 + i), d: 32'(32'hA000 + i), lk: 1'b0});
            q1.push_back('{a: 8'(8'h20 + i), d: 32'(32'hB000 + i), lk: 1'b0});
        end
        wait_quiet(200);
        for (int k = 0; k < 8; k++) check("t2_order", 32'(rdy_idx[rb + k]), 32'(k % 2));
        for (int k = 1; k < 8; k++) check("t2_space", 32'(stb_cyc[sb + k] - stb_cyc[sb + k - 1]), 32'd5);
        check("t2_addr1", 32'(stb_addr[sb + 1]), 32'h20);
        check("t2_count", 32'(wr_count), 32'd8);

        // Backpressure: buffer not ready for 10 cycles after the grant.
        rb = rdy_cyc.size(); sb = stb_cyc.size();
        buf_rdy = 1'b0;
        q0.push_back('{a: 8'h33, d: 32'h12345678, lk: 1'b0});
        wait_grant(rb);
        repeat (10) next_cycle();
        check("t3_nostb", 32'(stb_cyc.size() - sb), 32'd0);
        check("t3_stable", 32'(wr_addr), 32'h33);
        buf_rdy = 1'b1;
        wait_quiet(40);
        check("t3_lat",  32'(stb_cyc[sb] - rdy_cyc[rb]), 32'd11);
        check("t3_data", stb_data[sb], 32'h12345678);
        check("t3_count", 32'(wr_count), 32'd9);

        // Reset in HOLD: outputs clear at once, next grant from requester 0.
        sb = stb_cyc.size();
        q0.push_back('{a: 8'h44, d: 32'hA5A5A5A5, lk: 1'b0});
        wait_strobe(sb);
        rst = 1'b1;
        q0.delete(); q1.delete();
        #1;
        check("t4h_addr",  32'(wr_addr), 32'h0);
        check("t4h_data",  wr_data, 32'h0);
        check("t4h_count", 32'(wr_count), 32'h0);
        check("t4h_valid", 32'(wr_valid), 32'h0);
        repeat (2) next_cycle();
        rst = 1'b0;
        next_cycle();
        rb = rdy_cyc.size();
        q0.push_back('{a: 8'h45, d: 32'h1, lk: 1'b0});
        q1.push_back('{a: 8'h46, d: 32'h2, lk: 1'b0});
        wait_quiet(60);
        check("t4h_first", 32'(rdy_idx[rb]), 32'd0);

        // Reset in SEND: the stalled write never strobes.
        rb = rdy_cyc.size();
        buf_rdy = 1'b0;
        q0.push_back('{a: 8'h55, d: 32'h0BADF00D, lk: 1'b0});
        wait_grant(rb);
        sb = stb_cyc.size();
        rst = 1'b1;
        q0.delete(); q1.delete();
        #1;
        check("t4s_addr",  32'(wr_addr), 32'h0);
        check("t4s_gid",   32'(grant_id), 32'h0);
        check("t4s_count", 32'(wr_count), 32'h0);
        buf_rdy = 1'b1;
        repeat (2) next_cycle();
        rst = 1'b0;
        next_cycle();
        check("t4s_nostb", 32'(stb_cyc.size() - sb), 32'd0);
        rb = rdy_cyc.size();
        q0.push_back('{a: 8'h56, d: 32'h3, lk: 1'b0});
        q1.push_back('{a: 8'h57, d: 32'h4, lk: 1'b0});
        wait_quiet(60);
        check("t4s_first", 32'(rdy_idx[rb]), 32'd0);
        check("t4s_a0",    32'(stb_addr[sb]), 32'h56);
        check("t4s_a1",    32'(stb_addr[sb + 1]), 32'h57);

        // Counter wrap: 17 writes on a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) q0.push_back('{a: 8'(i), d: 32'(i * 3), lk: 1'b0});
        wait_quiet(200);
        check("t5_wrap", 32'(wr_count), 32'd1);

        // Burst lock: requester 1 sends three locked writes while 0 waits.
        do_reset();
        q0.push_back('{a: 8'h60, d: 32'h60, lk: 1'b0});
        wait_quiet(40);
        rb = rdy_cyc.size();
        for (int i = 0; i < 3; i++) q1.push_back('{a: 8'(8'h71 + i), d: 32'(32'h70 + i), lk: 1'b1});
        q0.push_back('{a: 8'h61, d: 32'h61, lk: 1'b0});
        wait_quiet(100);
`ifdef VX_DCR_ARB_LOCK_EN
        check("t6_g0", 32'(rdy_idx[rb]),     32'd1);
        check("t6_g1", 32'(rdy_idx[rb + 1]), 32'd1);
        check("t6_g2", 32'(rdy_idx[rb + 2]), 32'd1);
        check("t6_g3", 32'(rdy_idx[rb + 3]), 32'd0);
`else
        check("t6_g0", 32'(rdy_idx[rb]),     32'd1);
        check("t6_g1", 32'(rdy_idx[rb + 1]), 32'd0);
        check("t6_g2", 32'(rdy_idx[rb + 2]), 32'd1);
        check("t6_g3", 32'(rdy_idx[rb + 3]), 32'd1);
`endif

        repeat (3) next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
